// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: bundle of every handshake, forwarding and result signal
// between decode, the ID/EX stage, and the ALU/MEM side.
//   master : decode / forwarding sources / downstream consumer (drives in_*,
//            fwd_*, flush, out_ready; observes stage outputs)
//   slave  : the id_ex_stage itself
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits on ready, and a held transfer stays bit-stable
// until accepted.
interface id_ex_stage_if #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
);
  // decode side
  logic             in_valid;
  logic             in_ready;
  logic [RADDR-1:0] in_rs1_addr;
  logic [RADDR-1:0] in_rs2_addr;
  logic [XLEN-1:0]  in_rs1_data;
  logic [XLEN-1:0]  in_rs2_data;
  logic [XLEN-1:0]  in_imm;
  logic             in_use_imm;
  logic             in_uses_rs2;
  logic [2:0]       in_alu_control;
  logic [RADDR-1:0] in_rd;
  logic             in_reg_write;
  logic             in_mem_read;
  logic             in_mem_write;
  logic             flush;
  // forwarding sources
  logic             fwd_ex_valid;
  logic [RADDR-1:0] fwd_ex_rd;
  logic [XLEN-1:0]  fwd_ex_data;
  logic             fwd_ex_is_load;
  logic             fwd_wb_valid;
  logic [RADDR-1:0] fwd_wb_rd;
  logic [XLEN-1:0]  fwd_wb_data;
  // ALU / MEM side
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  alu_a;
  logic [XLEN-1:0]  alu_b;
  logic [2:0]       alu_control;
  logic [XLEN-1:0]  out_store_data;
  logic [RADDR-1:0] out_rd;
  logic             out_reg_write;
  logic             out_mem_read;
  logic             out_mem_write;
  logic             hazard_stall;
  logic [15:0]      stall_count;

  modport master (
    output in_valid, in_rs1_addr, in_rs2_addr, in_rs1_data, in_rs2_data,
           in_imm, in_use_imm, in_uses_rs2, in_alu_control, in_rd,
           in_reg_write, in_mem_read, in_mem_write, flush,
           fwd_ex_valid, fwd_ex_rd, fwd_ex_data, fwd_ex_is_load,
           fwd_wb_valid, fwd_wb_rd, fwd_wb_data, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_control, out_store_data,
           out_rd, out_reg_write, out_mem_read, out_mem_write,
           hazard_stall, stall_count
  );

  modport slave (
    input  in_valid, in_rs1_addr, in_rs2_addr, in_rs1_data, in_rs2_data,
           in_imm, in_use_imm, in_uses_rs2, in_alu_control, in_rd,
           in_reg_write, in_mem_read, in_mem_write, flush,
           fwd_ex_valid, fwd_ex_rd, fwd_ex_data, fwd_ex_is_load,
           fwd_wb_valid, fwd_wb_rd, fwd_wb_data, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_control, out_store_data,
           out_rd, out_reg_write, out_mem_read, out_mem_write,
           hazard_stall, stall_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: one-entry ID/EX pipeline register. Resolves rs1/rs2 by
// forwarding from EX/MEM then MEM/WB, selects ALU operand B, detects
// load-use hazards and presents registered ALU operands plus MEM control.
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   bus        : id_ex_stage_if.slave, all handshake/datapath signals
//   dbg_full_o : FSM state (1 = FULL, 0 = EMPTY)
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  id_ex_stage_if.slave bus,
  output logic         dbg_full_o
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e           state_q;
  logic [XLEN-1:0]  alu_a_q, alu_b_q, store_data_q;
  logic [2:0]       alu_control_q;
  logic [RADDR-1:0] rd_q;
  logic             reg_write_q, mem_read_q, mem_write_q;
  logic [15:0]      stall_count_q;

  logic             rs1_ex_hit, rs1_wb_hit, rs2_ex_hit, rs2_wb_hit;
  logic [XLEN-1:0]  rs1_fwd, rs2_fwd;
  logic             load_use, in_ready, capture, full;

  assign full = (state_q == FULL);

  // A load in EX has no data yet, so it is never an EX forwarding source;
  // that case is covered by the load-use bubble instead.
  assign rs1_ex_hit = bus.fwd_ex_valid && !bus.fwd_ex_is_load &&
                      (bus.fwd_ex_rd == bus.in_rs1_addr) && (bus.in_rs1_addr != '0);
  assign rs1_wb_hit = bus.fwd_wb_valid &&
                      (bus.fwd_wb_rd == bus.in_rs1_addr) && (bus.in_rs1_addr != '0);
  assign rs2_ex_hit = bus.fwd_ex_valid && !bus.fwd_ex_is_load &&
                      (bus.fwd_ex_rd == bus.in_rs2_addr) && (bus.in_rs2_addr != '0);
  assign rs2_wb_hit = bus.fwd_wb_valid &&
                      (bus.fwd_wb_rd == bus.in_rs2_addr) && (bus.in_rs2_addr != '0);

  assign rs1_fwd = rs1_ex_hit ? bus.fwd_ex_data :
                   rs1_wb_hit ? bus.fwd_wb_data : bus.in_rs1_data;
  assign rs2_fwd = rs2_ex_hit ? bus.fwd_ex_data :
                   rs2_wb_hit ? bus.fwd_wb_data : bus.in_rs2_data;

  // rs2 only counts as a dependency when the instruction actually reads it.
  assign load_use = bus.in_valid && bus.fwd_ex_valid && bus.fwd_ex_is_load &&
                    (bus.fwd_ex_rd != '0) &&
                    ((bus.fwd_ex_rd == bus.in_rs1_addr) ||
                     (bus.in_uses_rs2 && (bus.fwd_ex_rd == bus.in_rs2_addr)));

  assign in_ready = (!full || bus.out_ready) && !load_use && !bus.flush;
  assign capture  = bus.in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= EMPTY;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      store_data_q  <= '0;
      alu_control_q <= 3'b000;
      rd_q          <= '0;
      reg_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      stall_count_q <= '0;
    end else begin
      // Counts independently of flush so stall statistics survive redirects.
      if (load_use && (stall_count_q != 16'hFFFF))
        stall_count_q <= stall_count_q + 16'd1;

      if (bus.flush) begin
        state_q <= EMPTY;
      end else if (capture) begin
        state_q       <= FULL;
        alu_a_q       <= rs1_fwd;
        alu_b_q       <= bus.in_use_imm ? bus.in_imm : rs2_fwd;
        store_data_q  <= rs2_fwd;
        alu_control_q <= bus.in_alu_control;
        rd_q          <= bus.in_rd;
        reg_write_q   <= bus.in_reg_write;
        mem_read_q    <= bus.in_mem_read;
        mem_write_q   <= bus.in_mem_write;
      end else if (full && bus.out_ready) begin
        // Drain only; data registers keep their last values.
        state_q <= EMPTY;
      end
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.hazard_stall   = load_use;
  assign bus.out_valid      = full;
  assign bus.alu_a          = alu_a_q;
  assign bus.alu_b          = alu_b_q;
  assign bus.out_store_data = store_data_q;
  assign bus.alu_control    = alu_control_q;
  assign bus.out_rd         = rd_q;
  assign bus.out_reg_write  = reg_write_q;
  assign bus.out_mem_read   = mem_read_q;
  assign bus.out_mem_write  = mem_write_q;
  assign bus.stall_count    = stall_count_q;
  assign dbg_full_o         = full;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  localparam int W = 107;  // packed {alu_a, alu_b, store, ctl, rd, rw, mr, mw}

  logic clk;
  logic rst_n;
  logic dbg_full;
  int   tests;
  int   fails;
  logic [W-1:0] exp_q[$];

  id_ex_stage_if #(.XLEN(32), .RADDR(5)) bus ();

  id_ex_stage #(.XLEN(32), .RADDR(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .dbg_full_o (dbg_full)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- check helper ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid       = 1'b0;
    bus.in_rs1_addr    = '0;
    bus.in_rs2_addr    = '0;
    bus.in_rs1_data    = '0;
    bus.in_rs2_data    = '0;
    bus.in_imm         = '0;
    bus.in_use_imm     = 1'b0;
    bus.in_uses_rs2    = 1'b0;
    bus.in_alu_control = 3'b000;
    bus.in_rd          = '0;
    bus.in_reg_write   = 1'b0;
    bus.in_mem_read    = 1'b0;
    bus.in_mem_write   = 1'b0;
    bus.flush          = 1'b0;
    bus.fwd_ex_valid   = 1'b0;
    bus.fwd_ex_rd      = '0;
    bus.fwd_ex_data    = '0;
    bus.fwd_ex_is_load = 1'b0;
    bus.fwd_wb_valid   = 1'b0;
    bus.fwd_wb_rd      = '0;
    bus.fwd_wb_data    = '0;
    bus.out_ready      = 1'b1;
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [31:0] d1,
                       input logic [4:0] rs2, input logic [31:0] d2,
                       input logic [31:0] imm, input logic use_imm, input logic uses_rs2,
                       input logic [2:0] ctl, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic mw);
    bus.in_valid       = 1'b1;
    bus.in_rs1_addr    = rs1;
    bus.in_rs1_data    = d1;
    bus.in_rs2_addr    = rs2;
    bus.in_rs2_data    = d2;
    bus.in_imm         = imm;
    bus.in_use_imm     = use_imm;
    bus.in_uses_rs2    = uses_rs2;
    bus.in_alu_control = ctl;
    bus.in_rd          = rd;
    bus.in_reg_write   = rw;
    bus.in_mem_read    = mr;
    bus.in_mem_write   = mw;
  endtask

  task automatic set_ex(input logic v, input logic [4:0] rd, input logic [31:0] d, input logic ld);
    bus.fwd_ex_valid   = v;
    bus.fwd_ex_rd      = rd;
    bus.fwd_ex_data    = d;
    bus.fwd_ex_is_load = ld;
  endtask

  task automatic set_wb(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.fwd_wb_valid = v;
    bus.fwd_wb_rd    = rd;
    bus.fwd_wb_data  = d;
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] b, input logic [31:0] sd,
                          input logic [2:0] ctl, input logic [4:0] rd,
                          input logic rw, input logic mr, input logic mw);
    exp_q.push_back({a, b, sd, ctl, rd, rw, mr, mw});
  endtask

  // ---------------- scoreboard monitor ----------------
  // Outputs are stable from posedge+1 to the next posedge; a transfer seen at
  // the negedge is the one consumed at the following rising edge.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_output", 128'(bus.alu_a), 128'hDEAD_0000);
      end else begin
        check("sb_output", 128'({bus.alu_a, bus.alu_b, bus.out_store_data, bus.alu_control,
                                 bus.out_rd, bus.out_reg_write, bus.out_mem_read,
                                 bus.out_mem_write}),
              128'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    tests = 0;
    fails = 0;
    idle();
    rst_n = 1'b0;
    #12;
    check("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("rst_alu_a", 128'(bus.alu_a), 128'(0));
    check("rst_stall_count", 128'(bus.stall_count), 128'(0));
    check("rst_in_ready", 128'(bus.in_ready), 128'(1));
    check("rst_dbg_state", 128'(dbg_full), 128'(0));
    tick();
    rst_n = 1'b1;
    tick();

    // EX forwarding wins over WB
    set_ex(1'b1, 5'd5, 32'hAA, 1'b0);
    set_wb(1'b1, 5'd5, 32'hBB);
    drive(5'd5, 32'h1, 5'd0, 32'h22, 32'h0, 1'b0, 1'b1, 3'b010, 5'd3, 1'b1, 1'b0, 1'b0);
    #1;
    check("ex_prio_in_ready", 128'(bus.in_ready), 128'(1));
    push_exp(32'hAA, 32'h22, 32'h22, 3'b010, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    check("latency_out_valid", 128'(bus.out_valid), 128'(1));
    check("dbg_state_full", 128'(dbg_full), 128'(1));

    // x0 is never forwarded
    set_ex(1'b1, 5'd0, 32'hAA, 1'b0);
    set_wb(1'b1, 5'd0, 32'hBB);
    drive(5'd0, 32'h77, 5'd6, 32'h10, 32'h0, 1'b0, 1'b1, 3'b000, 5'd4, 1'b1, 1'b0, 1'b0);
    push_exp(32'h77, 32'h10, 32'h10, 3'b000, 5'd4, 1'b1, 1'b0, 1'b0);
    tick();

    // WB forward on rs1, EX forward on rs2
    set_ex(1'b1, 5'd4, 32'hCC, 1'b0);
    set_wb(1'b1, 5'd9, 32'hBB);
    drive(5'd9, 32'h3, 5'd4, 32'h44, 32'h0, 1'b0, 1'b1, 3'b111, 5'd5, 1'b1, 1'b0, 1'b0);
    push_exp(32'hBB, 32'hCC, 32'hCC, 3'b111, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();

    // load-use on rs2
    set_ex(1'b1, 5'd7, 32'hEE, 1'b1);
    set_wb(1'b0, 5'd0, 32'h0);
    drive(5'd1, 32'h11, 5'd7, 32'h66, 32'h0, 1'b0, 1'b1, 3'b000, 5'd0, 1'b0, 1'b0, 1'b1);
    #1;
    check("lu_in_ready", 128'(bus.in_ready), 128'(0));
    check("lu_hazard", 128'(bus.hazard_stall), 128'(1));
    tick();
    check("lu_stall_count", 128'(bus.stall_count), 128'(1));
    check("lu_bubble_valid", 128'(bus.out_valid), 128'(0));
    set_ex(1'b0, 5'd0, 32'h0, 1'b0);
    set_wb(1'b1, 5'd7, 32'h55);
    #1;
    check("lu_clear_hazard", 128'(bus.hazard_stall), 128'(0));
    check("lu_clear_ready", 128'(bus.in_ready), 128'(1));
    push_exp(32'h11, 32'h55, 32'h55, 3'b000, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();

    // immediate select; EX load matches rs2 only and rs2 is unused: no stall
    set_ex(1'b1, 5'd8, 32'hEE, 1'b1);
    set_wb(1'b1, 5'd8, 32'h9);
    drive(5'd2, 32'h2, 5'd8, 32'h0, 32'hFFFF_FFFC, 1'b1, 1'b0, 3'b000, 5'd6, 1'b1, 1'b0, 1'b0);
    #1;
    check("imm_no_stall", 128'(bus.hazard_stall), 128'(0));
    push_exp(32'h2, 32'hFFFF_FFFC, 32'h9, 3'b000, 5'd6, 1'b1, 1'b0, 1'b0);
    tick();

    // backpressure
    set_ex(1'b0, 5'd0, 32'h0, 1'b0);
    set_wb(1'b0, 5'd0, 32'h0);
    drive(5'd0, 32'hA0A0, 5'd0, 32'h0, 32'h10, 1'b1, 1'b0, 3'b001, 5'd10, 1'b1, 1'b0, 1'b0);
    push_exp(32'hA0A0, 32'h10, 32'h0, 3'b001, 5'd10, 1'b1, 1'b0, 1'b0);
    tick();
    bus.out_ready = 1'b0;
    drive(5'd0, 32'hB0B0, 5'd0, 32'h0, 32'h20, 1'b1, 1'b0, 3'b011, 5'd11, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready", 128'(bus.in_ready), 128'(0));
      check("bp_hold", 128'({bus.out_valid, bus.alu_a, bus.alu_b, bus.alu_control, bus.out_rd}),
            128'({1'b1, 32'hA0A0, 32'h10, 3'b001, 5'd10}));
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", 128'(bus.in_ready), 128'(1));
    push_exp(32'hB0B0, 32'h20, 32'h0, 3'b011, 5'd11, 1'b1, 1'b0, 1'b0);
    tick();
    check("bp_swap_valid", 128'(bus.out_valid), 128'(1));
    check("bp_swap_alu_a", 128'(bus.alu_a), 128'(32'hB0B0));
    bus.in_valid = 1'b0;
    tick();
    check("drain_valid", 128'(bus.out_valid), 128'(0));

    // flush kills held and incoming instructions
    bus.out_ready = 1'b0;
    drive(5'd0, 32'hC0C0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000, 5'd12, 1'b1, 1'b0, 1'b0);
    tick();
    drive(5'd0, 32'hD0D0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000, 5'd13, 1'b1, 1'b0, 1'b0);
    bus.flush = 1'b1;
    #1;
    check("flush_in_ready", 128'(bus.in_ready), 128'(0));
    tick();
    check("flush_out_valid", 128'(bus.out_valid), 128'(0));
    check("flush_data_kept", 128'(bus.alu_a), 128'(32'hC0C0));
    check("flush_stall_count", 128'(bus.stall_count), 128'(1));
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    check("flush_lost", 128'(bus.out_valid), 128'(0));

    // asynchronous reset mid-stream
    bus.out_ready = 1'b0;
    drive(5'd0, 32'h1234, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b101, 5'd14, 1'b1, 1'b1, 1'b0);
    tick();
    check("pre_rst_alu_a", 128'(bus.alu_a), 128'(32'h1234));
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 128'(bus.out_valid), 128'(0));
    check("async_rst_alu_a", 128'(bus.alu_a), 128'(0));
    check("async_rst_ctl_flags", 128'({bus.alu_control, bus.out_rd, bus.out_reg_write,
                                        bus.out_mem_read, bus.stall_count}), 128'(0));
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    check("post_rst_valid", 128'(bus.out_valid), 128'(0));
    check("sb_queue_empty", 128'(exp_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
